// File: rtl/svc_rv_dmem_cache_resp.sv
// Data-memory responder for the dcache fill/writeback port.
// Fixed-latency reads and writes on a word-addressed 32-bit array.
module svc_rv_dmem_cache_resp #(
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LATENCY = 4,
  parameter int WR_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cache_rd_valid,
  output logic        cache_rd_ready,
  input  logic [31:0] cache_rd_addr,
  output logic [31:0] cache_rd_data,
  output logic        cache_rd_data_valid,
  input  logic        cache_wr_valid,
  output logic        cache_wr_ready,
  input  logic [31:0] cache_wr_addr,
  input  logic [31:0] cache_wr_data,
  input  logic [3:0]  cache_wr_strb,
  output logic        busy,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_RESP,
    WR_WAIT,
    WR_ACK
  } state_t;

  localparam logic [3:0] RD_LOAD = 4'(RD_LATENCY - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_LATENCY - 1);

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [ADDR_WIDTH-1:0] rd_idx_q;
  logic [ADDR_WIDTH-1:0] wr_idx_q;
  logic [31:0] wr_data_q;
  logic [3:0]  wr_strb_q;

  logic [31:0] mem [2**ADDR_WIDTH];

  logic is_idle;
  logic rd_accept;
  logic wr_accept;
  logic rd_done;
  logic commit;

  logic unused_addr;
  assign unused_addr = ^{cache_rd_addr[31:ADDR_WIDTH+2],
                         cache_rd_addr[1:0],
                         cache_wr_addr[31:ADDR_WIDTH+2],
                         cache_wr_addr[1:0]};

  assign is_idle   = (state_q == IDLE);
  assign rd_accept = is_idle && cache_rd_valid;
  assign wr_accept = is_idle && cache_wr_valid && !cache_rd_valid;
  assign rd_done   = (state_q == RD_WAIT) && (cnt_q == 4'd0);
  assign commit    = (state_q == WR_ACK) && cache_wr_valid;

  assign cache_rd_ready      = is_idle;
  assign cache_rd_data_valid = (state_q == RD_RESP);
  assign cache_wr_ready      = (state_q == WR_ACK);
  assign busy                = !is_idle;

  // Next state and latency countdown.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (cache_rd_valid) begin
          state_d = RD_WAIT;
          cnt_d   = RD_LOAD;
        end else if (cache_wr_valid) begin
          state_d = WR_WAIT;
          cnt_d   = WR_LOAD;
        end
      end
      RD_WAIT: begin
        if (cnt_q == 4'd0) state_d = RD_RESP;
        else cnt_d = cnt_q - 4'd1;
      end
      WR_WAIT: begin
        if (cnt_q == 4'd0) state_d = WR_ACK;
        else cnt_d = cnt_q - 4'd1;
      end
      RD_RESP: state_d = IDLE;
      WR_ACK:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state, read data register and completion counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      cache_rd_data <= 32'd0;
      rd_count      <= 32'd0;
      wr_count      <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (rd_done) cache_rd_data <= mem[rd_idx_q];
      if (state_q == RD_RESP) rd_count <= rd_count + 32'd1;
      if (commit) wr_count <= wr_count + 32'd1;
    end
  end

  // Request capture; contents only matter once accepted.
  always_ff @(posedge clk) begin
    if (rd_accept) rd_idx_q <= cache_rd_addr[ADDR_WIDTH+1:2];
    if (wr_accept) begin
      wr_idx_q  <= cache_wr_addr[ADDR_WIDTH+1:2];
      wr_data_q <= cache_wr_data;
      wr_strb_q <= cache_wr_strb;
    end
  end

  // Byte-masked array write; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb_q[b]) mem[wr_idx_q][8*b +: 8] <= wr_data_q[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/svc_rv_dmem_cache_resp.md
SVC_RV_DMEM_CACHE_RESP -- requirements
Module: svc_rv_dmem_cache_resp

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, giving log2 of word depth (1024 x 32-bit words).
REQ-002 The block SHALL have parameter RD_LATENCY, default 4, giving cycles from read accept to data; legal range 1..15.
REQ-003 The block SHALL have parameter WR_LATENCY, default 2, giving cycles from write first seen to wr_ready; legal range 1..15.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port cache_rd_valid, input, 1 bit: read request, held by the initiator until cache_rd_data_valid.
REQ-007 The block SHALL have port cache_rd_ready, output, 1 bit: read request acceptance.
REQ-008 The block SHALL have port cache_rd_addr, input, 32 bits: read byte address.
REQ-009 The block SHALL have port cache_rd_data, output, 32 bits: read data.
REQ-010 The block SHALL have port cache_rd_data_valid, output, 1 bit: one-cycle read data strobe.
REQ-011 The block SHALL have port cache_wr_valid, input, 1 bit: write request, held until handshake.
REQ-012 The block SHALL have port cache_wr_ready, output, 1 bit: write acceptance.
REQ-013 The block SHALL have port cache_wr_addr, input, 32 bits: write byte address.
REQ-014 The block SHALL have port cache_wr_data, input, 32 bits: write data.
REQ-015 The block SHALL have port cache_wr_strb, input, 4 bits: byte enables, bit n enables byte n.
REQ-016 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-017 The block SHALL have port rd_count, output, 32 bits: completed reads, wrapping.
REQ-018 The block SHALL have port wr_count, output, 32 bits: committed writes, wrapping.

Function
REQ-019 The block SHALL use FSM states IDLE, RD_WAIT, RD_RESP, WR_WAIT and WR_ACK.
REQ-020 The block SHALL drive cache_rd_ready high only in IDLE.
REQ-021 In IDLE with cache_rd_valid=1, the block SHALL accept the read regardless of cache_wr_valid; reads have priority over writes.
REQ-022 On read accept, the block SHALL latch word index cache_rd_addr[ADDR_WIDTH+1:2] and ignore address bits [1:0] and all bits above ADDR_WIDTH+1.
REQ-023 On read accept, the block SHALL load the latency counter with RD_LATENCY-1.
REQ-024 The block SHALL assert cache_rd_data_valid for exactly one cycle, in RD_RESP, exactly RD_LATENCY cycles after the accept edge.
REQ-025 The block SHALL present cache_rd_data = mem[latched index] in the RD_RESP cycle, and hold cache_rd_data at that value until the next read response.
REQ-026 In IDLE with cache_wr_valid=1 and cache_rd_valid=0, the block SHALL latch wr address, data and strb, load the counter with WR_LATENCY-1, and enter WR_WAIT.
REQ-027 When the counter reaches 0, RD_WAIT SHALL go to RD_RESP and WR_WAIT SHALL go to WR_ACK; otherwise the counter SHALL decrement each cycle.
REQ-028 The block SHALL drive cache_wr_ready high only in WR_ACK, for one cycle, so that it occurs WR_LATENCY cycles after the write was first seen.
REQ-029 The block SHALL update strobed bytes from the latched data at the WR_ACK edge only if cache_wr_valid=1; if valid has dropped, it SHALL commit nothing.
REQ-030 RD_RESP and WR_ACK SHALL always return to IDLE next cycle; a request held or new in that next cycle SHALL be accepted as a new request.
REQ-031 The block SHALL ignore cache_rd_valid and cache_wr_valid in all non-IDLE states other than the WR_ACK check.
REQ-032 cache_rd_data_valid and cache_wr_ready SHALL never be high in the same cycle.
REQ-033 rd_count SHALL increment on each RD_RESP cycle, wrap from 0xFFFFFFFF to 0, and increment only.
REQ-034 wr_count SHALL increment on each committed write, wrap from 0xFFFFFFFF to 0, and increment only.
REQ-035 A write with strb=0 SHALL complete the handshake, leave memory unchanged, and increment wr_count.

Reset
REQ-036 While rst_n=0, the block SHALL hold state=IDLE, counter=0, cache_rd_data=0, cache_rd_data_valid=0, cache_wr_ready=0, busy=0, rd_count=0 and wr_count=0.
REQ-037 cache_rd_ready SHALL be 1 one cycle after rst_n deasserts, and during reset it SHALL follow IDLE, i.e. be 1.
REQ-038 Memory contents SHALL NOT be reset.
REQ-039 Reset mid-operation SHALL abandon the pending request: no data strobe, no write commit, and no count change.

Verification
REQ-040 Write 0xDEADBEEF to 0x100 with strb=0xF, then read 0x100 -> wr_ready 2 cycles after valid; rd_data_valid 4 cycles after accept with data 0xDEADBEEF; wr_count=1, rd_count=1.
REQ-041 Preload 0x11223344 at 0x20; write 0x000000AA to 0x22 with strb=0x1 -> read 0x20 returns 0x112233AA (bits[1:0] ignored).
REQ-042 rd_valid and wr_valid both high in IDLE -> read completes first; write handshakes afterwards; cache_rd_data_valid and cache_wr_ready are never high together.
REQ-043 Assert rst_n=0 during RD_WAIT, cycle 2 of 4 -> no rd_data_valid pulse; rd_count stays 0; IDLE after release.
REQ-044 Drop wr_valid before WR_ACK -> no memory change; wr_count unchanged; returns to IDLE.
REQ-045 Back-to-back held rd_valid across RD_RESP -> second read accepted in the IDLE cycle after the pulse; pulses separated by RD_LATENCY+1 cycles.
